// File: rtl/wb_host_master_pkg.sv
// Shared types and helpers for the Wishbone host master: FSM states, the
// buffered command record and the target-window check.
package wb_host_master_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [31:0] WB_BASE_DEFAULT = 32'h3000_0000;

    // Packed layout: we at bit 68, addr 67:36, data 35:4, sel 3:0.
    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  sel;
    } cmd_t;

    localparam int CMD_W = $bits(cmd_t);

    // True when addr lies in [base, base + 2**win_w).
    function automatic logic in_window(input logic [31:0] addr,
                                       input logic [31:0] base,
                                       input int unsigned win_w);
        logic [32:0] diff;
        diff = {1'b0, addr} - {1'b0, base};
        return !diff[32] && ((diff[31:0] >> win_w) == 32'd0);
    endfunction

endpackage

// File: rtl/wb_cmd_fifo.sv
// Synchronous command FIFO with registered occupancy count; read data is
// presented combinationally from the head slot.
module wb_cmd_fifo #(
    parameter int WIDTH = 69,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == FULL_COUNT);
    assign empty   = (count == '0);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; only the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/wb_host_master.sv
// Wishbone classic initiator: one single-beat bus cycle per buffered command,
// with window check, ack timeout and a held response register.
module wb_host_master
    import wb_host_master_pkg::*;
#(
    parameter logic [31:0] WISHBONE_BASE_ADDR = WB_BASE_DEFAULT,
    parameter int unsigned WINDOW_WIDTH       = 12,
    parameter int          CMD_DEPTH          = 4,
    parameter int unsigned TIMEOUT_CYCLES     = 255,
    parameter int unsigned TIMEOUT_WIDTH      = 8
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_we,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_data,
    input  logic [3:0]  cmd_sel,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i,
    output logic        busy
);

    localparam logic [TIMEOUT_WIDTH-1:0] WAIT_LAST = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

    state_t                   state;
    logic [TIMEOUT_WIDTH-1:0] wait_cnt;
    cmd_t                     cmd_in;
    cmd_t                     head;
    logic [CMD_W-1:0]         head_bits;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic                     pop;

    assign cmd_in    = {cmd_we, cmd_addr, cmd_data, cmd_sel};
    assign head      = cmd_t'(head_bits);
    assign cmd_ready = !fifo_full;
    assign pop       = (state == IDLE) && !fifo_empty;
    assign busy      = !fifo_empty || (state != IDLE);

    wb_cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (CMD_DEPTH)
    ) u_fifo (
        .clk   (wb_clk_i),
        .rst   (wb_rst_i),
        .push  (cmd_valid),
        .pop   (pop),
        .din   (cmd_in),
        .dout  (head_bits),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            wbm_we_o  <= 1'b0;
            wbm_sel_o <= '0;
            wbm_adr_o <= '0;
            wbm_dat_o <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        if (in_window(head.addr, WISHBONE_BASE_ADDR, WINDOW_WIDTH)) begin
                            wbm_cyc_o <= 1'b1;
                            wbm_stb_o <= 1'b1;
                            wbm_we_o  <= head.we;
                            wbm_sel_o <= head.sel;
                            wbm_adr_o <= head.addr;
                            wbm_dat_o <= head.data;
                            wait_cnt  <= '0;
                            state     <= BUS;
                        end else begin
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_data  <= '0;
                            state     <= RESP;
                        end
                    end
                end
                BUS: begin
                    // Ack is checked first so a last-cycle ack beats the timeout.
                    if (wbm_ack_i) begin
                        wbm_cyc_o <= 1'b0;
                        wbm_stb_o <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_data  <= wbm_we_o ? 32'd0 : wbm_dat_i;
                        state     <= RESP;
                    end else if (wait_cnt == WAIT_LAST) begin
                        wbm_cyc_o <= 1'b0;
                        wbm_stb_o <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_data  <= '0;
                        state     <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + TIMEOUT_WIDTH'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
